// File: rtl/alu_control_seq_pkg.sv
// alu_ctrl_pkg: operation codes, ALU_Op class constants, funct7 patterns and
// FSM state type shared by the ALU control sequencer and its decoder.
package alu_ctrl_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_XOR  = 4'h2,
        OP_OR   = 4'h3,
        OP_AND  = 4'h4,
        OP_SLL  = 4'h5,
        OP_SRL  = 4'h6,
        OP_SRA  = 4'h7,
        OP_SLT  = 4'h8,
        OP_SLTU = 4'h9,
        OP_LUI  = 4'hA,
        OP_MUL  = 4'hB,
        OP_MULH = 4'hC,
        OP_DIV  = 4'hD,
        OP_REM  = 4'hE,
        OP_NOP  = 4'hF
    } alu_op_code_e;

    localparam logic [2:0] ALU_OP_R   = 3'b000;
    localparam logic [2:0] ALU_OP_I   = 3'b001;
    localparam logic [2:0] ALU_OP_LUI = 3'b010;
    localparam logic [2:0] ALU_OP_MEM = 3'b011;
    localparam logic [2:0] ALU_OP_BR  = 3'b100;

    localparam logic [6:0] FUNCT7_BASE   = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    // Divide-class ops run for DIV_CYCLES, every other multi-cycle op for MUL_CYCLES.
    function automatic logic is_div_op(input alu_op_code_e code);
        return (code == OP_DIV) || (code == OP_REM);
    endfunction

endpackage

// File: rtl/alu_control_seq_if.sv
// alu_control_seq_if: request/response bundle between the control unit
// (master) and the ALU control sequencer (slave).
interface alu_control_seq_if #(
    parameter int unsigned OP_WIDTH = 4
);
    logic                valid_i;
    logic                ready_o;
    logic                flush_i;
    logic [2:0]          ALU_Op_i;
    logic [2:0]          funct3_i;
    logic [6:0]          funct7_i;
    logic [OP_WIDTH-1:0] ALU_Operation_o;
    logic                op_valid_o;
    logic                stall_o;
    logic                illegal_o;

    modport master (
        output valid_i, flush_i, ALU_Op_i, funct3_i, funct7_i,
        input  ready_o, ALU_Operation_o, op_valid_o, stall_o, illegal_o
    );

    modport slave (
        input  valid_i, flush_i, ALU_Op_i, funct3_i, funct7_i,
        output ready_o, ALU_Operation_o, op_valid_o, stall_o, illegal_o
    );
endinterface

// File: rtl/alu_control_seq_decode.sv
// alu_decode: combinational {funct7, ALU_Op, funct3} -> {op code, multi-cycle, illegal}.
// M-extension encodings decode only when RV32M_EN is defined; otherwise they are illegal.
module alu_decode
    import alu_ctrl_pkg::*;
(
    input  logic [6:0]   i_funct7,
    input  logic [2:0]   i_alu_op,
    input  logic [2:0]   i_funct3,
    output alu_op_code_e o_code,
    output logic         o_is_multi,
    output logic         o_illegal
);

    // Anything not explicitly matched falls through as NOP + illegal.
    always_comb begin
        o_code     = OP_NOP;
        o_is_multi = 1'b0;
        o_illegal  = 1'b1;
        case (i_alu_op)
            ALU_OP_R: begin
                if (i_funct7 == FUNCT7_BASE) begin
                    o_illegal = 1'b0;
                    case (i_funct3)
                        3'b000:  o_code = OP_ADD;
                        3'b001:  o_code = OP_SLL;
                        3'b010:  o_code = OP_SLT;
                        3'b011:  o_code = OP_SLTU;
                        3'b100:  o_code = OP_XOR;
                        3'b101:  o_code = OP_SRL;
                        3'b110:  o_code = OP_OR;
                        default: o_code = OP_AND;
                    endcase
                end else if (i_funct7 == FUNCT7_ALT) begin
                    case (i_funct3)
                        3'b000:  begin o_code = OP_SUB; o_illegal = 1'b0; end
                        3'b101:  begin o_code = OP_SRA; o_illegal = 1'b0; end
                        default: ;
                    endcase
                end
`ifdef RV32M_EN
                else if (i_funct7 == FUNCT7_MULDIV) begin
                    case (i_funct3)
                        3'b000:  begin o_code = OP_MUL;  o_is_multi = 1'b1; o_illegal = 1'b0; end
                        3'b001:  begin o_code = OP_MULH; o_is_multi = 1'b1; o_illegal = 1'b0; end
                        3'b100:  begin o_code = OP_DIV;  o_is_multi = 1'b1; o_illegal = 1'b0; end
                        3'b110:  begin o_code = OP_REM;  o_is_multi = 1'b1; o_illegal = 1'b0; end
                        default: ;
                    endcase
                end
`endif
            end
            ALU_OP_I: begin
                case (i_funct3)
                    3'b000: begin o_code = OP_ADD;  o_illegal = 1'b0; end
                    3'b001: begin
                        if (i_funct7 == FUNCT7_BASE) begin
                            o_code    = OP_SLL;
                            o_illegal = 1'b0;
                        end
                    end
                    3'b010: begin o_code = OP_SLT;  o_illegal = 1'b0; end
                    3'b011: begin o_code = OP_SLTU; o_illegal = 1'b0; end
                    3'b100: begin o_code = OP_XOR;  o_illegal = 1'b0; end
                    3'b101: begin
                        if (i_funct7 == FUNCT7_BASE) begin
                            o_code    = OP_SRL;
                            o_illegal = 1'b0;
                        end else if (i_funct7 == FUNCT7_ALT) begin
                            o_code    = OP_SRA;
                            o_illegal = 1'b0;
                        end
                    end
                    3'b110:  begin o_code = OP_OR;  o_illegal = 1'b0; end
                    default: begin o_code = OP_AND; o_illegal = 1'b0; end
                endcase
            end
            ALU_OP_LUI: begin o_code = OP_LUI; o_illegal = 1'b0; end
            ALU_OP_MEM: begin o_code = OP_ADD; o_illegal = 1'b0; end
            ALU_OP_BR:  begin o_code = OP_SUB; o_illegal = 1'b0; end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_control_seq.sv
// alu_control_seq: registered ALU control with a multi-cycle sequencer for
// iterative multiply/divide. Optional feature macro: RV32M_EN (M-extension ops).
module alu_control_seq
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned OP_WIDTH   = 4,
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic             clk,
    input  logic             reset,
    alu_control_seq_if.slave bus
);

    localparam int unsigned MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES);
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    state_e              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [OP_WIDTH-1:0] r_op_code;
    logic                r_op_valid;
    logic                r_illegal;

    alu_op_code_e        w_dec_code;
    logic                w_dec_multi;
    logic                w_dec_illegal;
    logic                w_accept;
    logic [CNT_W-1:0]    w_load;

    alu_decode u_decode (
        .i_funct7   (bus.funct7_i),
        .i_alu_op   (bus.ALU_Op_i),
        .i_funct3   (bus.funct3_i),
        .o_code     (w_dec_code),
        .o_is_multi (w_dec_multi),
        .o_illegal  (w_dec_illegal)
    );

    assign w_accept = bus.valid_i & (r_state == IDLE) & ~bus.flush_i;
    assign w_load   = is_div_op(w_dec_code) ? DIV_LOAD : MUL_LOAD;

    // Sequencer FSM: op_valid is raised on the cnt 1->0 edge so the pulse lands
    // in the cnt==0 cycle, N cycles after accept; a flush that same cycle cannot retract it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_op_code  <= OP_WIDTH'(OP_NOP);
            r_op_valid <= 1'b0;
            r_illegal  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_op_valid <= 1'b0;
                    r_illegal  <= 1'b0;
                    if (w_accept) begin
                        r_op_code <= OP_WIDTH'(w_dec_code);
                        if (w_dec_multi) begin
                            r_state <= BUSY;
                            r_cnt   <= w_load;
                        end else begin
                            r_op_valid <= 1'b1;
                            r_illegal  <= w_dec_illegal;
                        end
                    end
                end
                BUSY: begin
                    r_illegal <= 1'b0;
                    if (bus.flush_i || (r_cnt == '0)) begin
                        r_state    <= IDLE;
                        r_cnt      <= '0;
                        r_op_valid <= 1'b0;
                    end else begin
                        r_cnt      <= r_cnt - CNT_W'(1);
                        r_op_valid <= (r_cnt == CNT_W'(1));
                    end
                end
            endcase
        end
    end

    assign bus.ready_o         = (r_state == IDLE);
    assign bus.ALU_Operation_o = r_op_code;
    assign bus.op_valid_o      = r_op_valid;
    assign bus.illegal_o       = r_illegal;
`ifdef RV32M_EN
    assign bus.stall_o         = (r_state == BUSY);
`else
    assign bus.stall_o         = 1'b0;
`endif

endmodule

// File: tb/tb_alu_control_seq.sv
// tb_alu_control_seq: directed vector table, multi-cycle corner sequences and a
// randomized run against a cycle-index reference model. Honours RV32M_EN.
module tb_alu_control_seq;

    localparam int unsigned MUL_N = 4;
    localparam int unsigned DIV_N = 32;
`ifdef RV32M_EN
    localparam bit M_EN = 1'b1;
`else
    localparam bit M_EN = 1'b0;
`endif
    // Base-ISA codes indexed by funct3 (ADD SLL SLT SLTU XOR SRL OR AND).
    localparam logic [3:0] R_TAB [8] = '{4'h0, 4'h5, 4'h8, 4'h9, 4'h2, 4'h6, 4'h3, 4'h4};

    typedef struct {
        logic [2:0] aop;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [3:0] code;
        logic       ill;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    vec_t        vecs[$];
    logic [3:0]  last_code;
    int          busy_end;
    logic [3:0]  e_code;
    logic        e_v;
    logic        e_ill;
    logic        r_rst, r_v, r_fl;
    logic [2:0]  r_aop, r_f3;
    logic [6:0]  r_f7;
    logic [3:0]  m_code;
    logic        m_ill;
    int unsigned m_lat;

    alu_control_seq_if #(.OP_WIDTH(4)) bus_if ();

    alu_control_seq #(
        .OP_WIDTH   (4),
        .MUL_CYCLES (MUL_N),
        .DIV_CYCLES (DIV_N)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] code, input logic v,
                           input logic ill, input logic rdy, input logic stl);
        chk({tag, ".code"},     32'(bus_if.ALU_Operation_o), 32'(code));
        chk({tag, ".op_valid"}, 32'(bus_if.op_valid_o),      32'(v));
        chk({tag, ".illegal"},  32'(bus_if.illegal_o),       32'(ill));
        chk({tag, ".ready"},    32'(bus_if.ready_o),         32'(rdy));
        chk({tag, ".stall"},    32'(bus_if.stall_o),         32'(stl));
    endtask

    task automatic drive(input logic v, input logic fl, input logic [2:0] aop,
                         input logic [2:0] f3, input logic [6:0] f7);
        bus_if.valid_i  = v;
        bus_if.flush_i  = fl;
        bus_if.ALU_Op_i = aop;
        bus_if.funct3_i = f3;
        bus_if.funct7_i = f7;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic add_vec(input logic [2:0] aop, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [3:0] code, input logic ill);
        vec_t v;
        v.aop = aop; v.f3 = f3; v.f7 = f7; v.code = code; v.ill = ill;
        vecs.push_back(v);
    endtask

    // Reference decode from the instruction-class rules; lat = cycles to op_valid.
    function automatic void ref_decode(input logic [2:0] aop, input logic [2:0] f3, input logic [6:0] f7,
                                       output logic [3:0] code, output logic ill, output int unsigned lat);
        code = 4'hF; ill = 1'b1; lat = 1;
        if (aop == 3'd0) begin
            if (f7 == 7'h00) begin
                code = R_TAB[f3]; ill = 1'b0;
            end else if (f7 == 7'h20 && f3 == 3'd0) begin
                code = 4'h1; ill = 1'b0;
            end else if (f7 == 7'h20 && f3 == 3'd5) begin
                code = 4'h7; ill = 1'b0;
            end else if (M_EN && f7 == 7'h01) begin
                if (f3 == 3'd0)      begin code = 4'hB; ill = 1'b0; lat = MUL_N; end
                else if (f3 == 3'd1) begin code = 4'hC; ill = 1'b0; lat = MUL_N; end
                else if (f3 == 3'd4) begin code = 4'hD; ill = 1'b0; lat = DIV_N; end
                else if (f3 == 3'd6) begin code = 4'hE; ill = 1'b0; lat = DIV_N; end
            end
        end else if (aop == 3'd1) begin
            if (f3 == 3'd1) begin
                if (f7 == 7'h00) begin code = 4'h5; ill = 1'b0; end
            end else if (f3 == 3'd5) begin
                if (f7 == 7'h00)      begin code = 4'h6; ill = 1'b0; end
                else if (f7 == 7'h20) begin code = 4'h7; ill = 1'b0; end
            end else begin
                code = R_TAB[f3]; ill = 1'b0;
            end
        end else if (aop == 3'd2) begin
            code = 4'hA; ill = 1'b0;
        end else if (aop == 3'd3) begin
            code = 4'h0; ill = 1'b0;
        end else if (aop == 3'd4) begin
            code = 4'h1; ill = 1'b0;
        end
    endfunction

    initial begin
        // Back-to-back single-cycle vectors: ADD, SUB, SRAI, LUI lead the table.
        add_vec(3'd0, 3'd0, 7'h00, 4'h0, 1'b0);
        add_vec(3'd0, 3'd0, 7'h20, 4'h1, 1'b0);
        add_vec(3'd1, 3'd5, 7'h20, 4'h7, 1'b0);
        add_vec(3'd2, 3'd3, 7'h11, 4'hA, 1'b0);
        add_vec(3'd0, 3'd4, 7'h00, 4'h2, 1'b0);
        add_vec(3'd0, 3'd6, 7'h00, 4'h3, 1'b0);
        add_vec(3'd0, 3'd7, 7'h00, 4'h4, 1'b0);
        add_vec(3'd0, 3'd1, 7'h00, 4'h5, 1'b0);
        add_vec(3'd0, 3'd5, 7'h00, 4'h6, 1'b0);
        add_vec(3'd0, 3'd2, 7'h00, 4'h8, 1'b0);
        add_vec(3'd0, 3'd3, 7'h00, 4'h9, 1'b0);
        add_vec(3'd1, 3'd1, 7'h00, 4'h5, 1'b0);
        add_vec(3'd1, 3'd5, 7'h00, 4'h6, 1'b0);
        add_vec(3'd1, 3'd0, 7'h55, 4'h0, 1'b0);
        add_vec(3'd1, 3'd6, 7'h7F, 4'h3, 1'b0);
        add_vec(3'd3, 3'd2, 7'h20, 4'h0, 1'b0);
        add_vec(3'd4, 3'd1, 7'h01, 4'h1, 1'b0);
        add_vec(3'd0, 3'd4, 7'h20, 4'hF, 1'b1);
        add_vec(3'd1, 3'd1, 7'h20, 4'hF, 1'b1);
        add_vec(3'd0, 3'd0, 7'h40, 4'hF, 1'b1);
        add_vec(3'd5, 3'd0, 7'h00, 4'hF, 1'b1);
        add_vec(3'd7, 3'd2, 7'h00, 4'hF, 1'b1);
        add_vec(3'd1, 3'd5, 7'h01, 4'hF, 1'b1);
        add_vec(3'd0, 3'd2, 7'h01, 4'hF, 1'b1);
`ifndef RV32M_EN
        add_vec(3'd0, 3'd0, 7'h01, 4'hF, 1'b1);
        add_vec(3'd0, 3'd4, 7'h01, 4'hF, 1'b1);
`endif

        // Reset held for two edges, then released.
        reset = 1'b1;
        drive(1'b0, 1'b0, 3'd0, 3'd0, 7'h00);
        step();
        step();
        chk_out("reset", 4'hF, 1'b0, 1'b0, 1'b1, 1'b0);
        reset = 1'b0;
        step();
        chk_out("post_reset", 4'hF, 1'b0, 1'b0, 1'b1, 1'b0);

        // Vector table, one request per cycle, result one cycle later.
        last_code = 4'hF;
        for (int i = 0; i < vecs.size(); i++) begin
            drive(1'b1, 1'b0, vecs[i].aop, vecs[i].f3, vecs[i].f7);
            step();
            chk_out($sformatf("vec%0d", i), vecs[i].code, 1'b1, vecs[i].ill, 1'b1, 1'b0);
            last_code = vecs[i].code;
        end
        drive(1'b0, 1'b0, 3'd0, 3'd0, 7'h00);
        step();
        chk_out("hold_idle", last_code, 1'b0, 1'b0, 1'b1, 1'b0);

        // Flush and valid together in IDLE: not accepted, code holds.
        drive(1'b1, 1'b1, 3'd2, 3'd0, 7'h00);
        step();
        chk_out("flush_idle", last_code, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 3'd2, 3'd0, 7'h00);
        step();
        chk_out("after_flush_lui", 4'hA, 1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 3'd0, 3'd0, 7'h00);
        step();

`ifdef RV32M_EN
        // DIV: stall for DIV_N cycles, single op_valid at the last; held ADD goes in afterwards.
        drive(1'b1, 1'b0, 3'd0, 3'd4, 7'h01);
        step();
        drive(1'b1, 1'b0, 3'd0, 3'd0, 7'h00);
        for (int k = 1; k <= int'(DIV_N); k++) begin
            chk_out($sformatf("div_busy%0d", k), 4'hD, (k == int'(DIV_N)), 1'b0, 1'b0, 1'b1);
            step();
        end
        chk_out("div_done_idle", 4'hD, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        chk_out("add_after_div", 4'h0, 1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 3'd0, 3'd0, 7'h00);
        step();

        // MUL flushed in its second busy cycle.
        drive(1'b1, 1'b0, 3'd0, 3'd0, 7'h01);
        step();
        drive(1'b0, 1'b0, 3'd0, 3'd0, 7'h00);
        chk_out("mul_busy1", 4'hB, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        drive(1'b0, 1'b1, 3'd0, 3'd0, 7'h00);
        chk_out("mul_busy2", 4'hB, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        drive(1'b0, 1'b0, 3'd0, 3'd0, 7'h00);
        chk_out("mul_flushed", 4'hB, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        chk_out("mul_flushed+1", 4'hB, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        chk_out("mul_flushed+2", 4'hB, 1'b0, 1'b0, 1'b1, 1'b0);

        // Same abort by reset.
        drive(1'b1, 1'b0, 3'd0, 3'd0, 7'h01);
        step();
        drive(1'b0, 1'b0, 3'd0, 3'd0, 7'h00);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_out("mul_reset", 4'hF, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        chk_out("mul_reset+1", 4'hF, 1'b0, 1'b0, 1'b1, 1'b0);

        // Flush in the completion cycle: op_valid still shows.
        drive(1'b1, 1'b0, 3'd0, 3'd1, 7'h01);
        step();
        drive(1'b0, 1'b0, 3'd0, 3'd0, 7'h00);
        for (int k = 1; k < int'(MUL_N); k++) step();
        drive(1'b0, 1'b1, 3'd0, 3'd0, 7'h00);
        chk_out("mulh_last_flush", 4'hC, 1'b1, 1'b0, 1'b0, 1'b1);
        step();
        drive(1'b0, 1'b0, 3'd0, 3'd0, 7'h00);
        chk_out("mulh_after", 4'hC, 1'b0, 1'b0, 1'b1, 1'b0);

        // Flush one cycle before completion: no op_valid.
        drive(1'b1, 1'b0, 3'd0, 3'd0, 7'h01);
        step();
        drive(1'b0, 1'b0, 3'd0, 3'd0, 7'h00);
        for (int k = 1; k < int'(MUL_N) - 1; k++) step();
        drive(1'b0, 1'b1, 3'd0, 3'd0, 7'h00);
        step();
        drive(1'b0, 1'b0, 3'd0, 3'd0, 7'h00);
        chk_out("mul_late_flush", 4'hB, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
`endif

        // Randomized run; the model tracks the cycle index at which a multi-cycle op completes.
        reset = 1'b1;
        drive(1'b0, 1'b0, 3'd0, 3'd0, 7'h00);
        step();
        reset = 1'b0;
        e_code = 4'hF; e_v = 1'b0; e_ill = 1'b0; busy_end = -1;
        for (int c = 0; c < 3000; c++) begin
            chk_out($sformatf("rand@%0d", c), e_code, e_v, e_ill, !(c <= busy_end), (c <= busy_end));
            r_rst = ($urandom_range(0, 63) == 0);
            r_v   = ($urandom_range(0, 3) != 0);
            r_fl  = ($urandom_range(0, 7) == 0);
            r_aop = ($urandom_range(0, 2) == 0) ? 3'd0 : 3'($urandom_range(0, 7));
            r_f3  = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0:       r_f7 = 7'h00;
                1:       r_f7 = 7'h20;
                2:       r_f7 = 7'h01;
                default: r_f7 = 7'($urandom);
            endcase
            reset = r_rst;
            drive(r_v, r_fl, r_aop, r_f3, r_f7);
            if (r_rst) begin
                busy_end = -1; e_code = 4'hF; e_v = 1'b0; e_ill = 1'b0;
            end else if (c <= busy_end) begin
                if (r_fl && c < busy_end) busy_end = c;
                e_v   = (c + 1 == busy_end);
                e_ill = 1'b0;
            end else begin
                e_v = 1'b0; e_ill = 1'b0;
                if (r_v && !r_fl) begin
                    ref_decode(r_aop, r_f3, r_f7, m_code, m_ill, m_lat);
                    e_code = m_code;
                    if (m_lat > 1) begin
                        busy_end = c + int'(m_lat);
                    end else begin
                        e_v   = 1'b1;
                        e_ill = m_ill;
                    end
                end
            end
            step();
        end
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
